// File: rtl/vload_assembler.sv
// Strided vector load: issues one memory read per lane, assembles the words into a
// register-wide vector, then writes it to the register file with a one-cycle we/done pulse.
module vload_assembler #(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 4,
  parameter int WORD_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     dst_reg,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  input  logic [MEM_ADDR_WIDTH-1:0] stride,
  output logic                      busy,
  output logic                      mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0]     mem_rd_data,
  input  logic                      mem_rd_valid,
  output logic                      we,
  output logic [ADDR_WIDTH-1:0]     w_addr,
  output logic [DATA_WIDTH-1:0]     w_data,
  output logic                      done
);
  localparam int LANES  = DATA_WIDTH / WORD_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     dst_q, dst_d;
  logic [MEM_ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [DATA_WIDTH-1:0]     vec_q, vec_d;
  logic [DATA_WIDTH-1:0]     w_data_q, w_data_d;
  logic [ADDR_WIDTH-1:0]     w_addr_q, w_addr_d;
  logic                      rd_en_q, rd_en_d;
  logic                      we_q, we_d;
  logic                      done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dst_q    <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      lane_q   <= '0;
      vec_q    <= '0;
      w_data_q <= '0;
      w_addr_q <= '0;
      rd_en_q  <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dst_q    <= dst_d;
      stride_q <= stride_d;
      addr_q   <= addr_d;
      lane_q   <= lane_d;
      vec_q    <= vec_d;
      w_data_q <= w_data_d;
      w_addr_q <= w_addr_d;
      rd_en_q  <= rd_en_d;
      we_q     <= we_d;
      done_q   <= done_d;
    end
  end

  // Strobes are computed one state ahead so they are flop outputs in the state they belong to.
  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    stride_d = stride_q;
    addr_d   = addr_q;
    lane_d   = lane_q;
    vec_d    = vec_q;
    w_data_d = w_data_q;
    w_addr_d = w_addr_q;
    rd_en_d  = 1'b0;
    we_d     = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dst_d    = dst_reg;
          stride_d = stride;
          addr_d   = base_addr;
          lane_d   = '0;
          rd_en_d  = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (mem_rd_valid) begin
          vec_d[int'(lane_q) * WORD_WIDTH +: WORD_WIDTH] = mem_rd_data;
          if (lane_q == LAST_LANE) begin
            w_data_d = vec_d;
            w_addr_d = dst_q;
            we_d     = 1'b1;
            done_d   = 1'b1;
            state_d  = WRITE;
          end else begin
            lane_d  = lane_q + LANE_W'(1);
            addr_d  = addr_q + stride_q;
            rd_en_d = 1'b1;
            state_d = REQ;
          end
        end
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign we        = we_q;
  assign w_addr    = w_addr_q;
  assign w_data    = w_data_q;
  assign done      = done_q;
endmodule

// File: tb/tb_vload_assembler.sv
// Directed bench for vload_assembler: a latency-programmable memory model feeds the DUT while
// address and write expectations are queued at stimulus time and popped as the DUT produces them.
module tb_vload_assembler;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   dst_reg;
  logic [15:0]  base_addr;
  logic [15:0]  stride;
  logic         busy;
  logic         mem_rd_en;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_rd_data;
  logic         mem_rd_valid;
  logic         we;
  logic [3:0]   w_addr;
  logic [127:0] w_data;
  logic         done;

  logic         mdl_vld;
  logic [31:0]  mdl_dat;
  logic         spur_vld;
  logic [31:0]  spur_dat;

  assign mem_rd_valid = mdl_vld | spur_vld;
  assign mem_rd_data  = mdl_vld ? mdl_dat : spur_dat;

  vload_assembler dut (
    .clk(clk), .rst(rst), .start(start), .dst_reg(dst_reg), .base_addr(base_addr),
    .stride(stride), .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .we(we), .w_addr(w_addr),
    .w_data(w_data), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   a;
    logic [127:0] d;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [15:0] exp_addr_q[$];
  int          lat_q[$];

  int n_asrt = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  bit pending = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [15:0] a);
    case (a)
      16'h0010: word_of = 32'h11111111;
      16'h0011: word_of = 32'h22222222;
      16'h0012: word_of = 32'h33333333;
      16'h0013: word_of = 32'h44444444;
      default:  word_of = {a ^ 16'h5A3C, a};
    endcase
  endfunction

  // Memory: one word per sampled request, returned after the next queued latency.
  initial begin
    logic [15:0] a;
    int l;
    mdl_vld = 1'b0;
    mdl_dat = '0;
    forever begin
      @(negedge clk);
      if (mem_rd_en === 1'b1 && rst === 1'b0) begin
        a = mem_addr;
        l = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        @(posedge clk);
        repeat (l - 1) @(posedge clk);
        #1;
        mdl_vld = 1'b1;
        mdl_dat = word_of(a);
        @(posedge clk);
        #1;
        mdl_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (mdl_vld) pending = 1'b0;
    if (mem_rd_en) begin
      rd_cnt++;
      chk("one_outstanding", pending, 1'b0);
      pending = 1'b1;
      if (exp_addr_q.size() > 0) chk("mem_addr", mem_addr, exp_addr_q.pop_front());
      else chk("unexpected_rd", mem_rd_en, 1'b0);
    end
    if (done) done_cnt++;
    if (we) begin
      we_cnt++;
      chk("done_with_we", done, 1'b1);
      if (exp_wr_q.size() > 0) begin
        e = exp_wr_q.pop_front();
        chk("w_addr", w_addr, e.a);
        chk("w_data", w_data, e.d);
      end else begin
        chk("unexpected_we", we, 1'b0);
      end
    end else if (done) begin
      chk("done_without_we", we, 1'b1);
    end
  end

  task automatic prep(input logic [3:0] d, input logic [15:0] b, input logic [15:0] s,
                      input int l0, input int l1, input int l2, input int l3);
    logic [15:0]  a;
    logic [127:0] v;
    int           lats[4];
    lats = '{l0, l1, l2, l3};
    dst_reg   = d;
    base_addr = b;
    stride    = s;
    a = b;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(a);
      v[i*32 +: 32] = word_of(a);
      lat_q.push_back(lats[i]);
      a = a + s;
    end
    exp_wr_q.push_back({d, v});
  endtask

  // Called #1 after an edge with the DUT in IDLE; returns #1 after the edge that raised done.
  task automatic go(input bit interfere, input bit hold, output int n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    spur_vld = interfere;
    spur_dat = 32'hDEADBEEF;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      spur_vld = 1'b0;
      n++;
      if (done) break;
      start = interfere & n[0];
      if (interfere) begin
        dst_reg   = 4'hE;
        base_addr = 16'hBAD0;
      end
    end
    if (done !== 1'b1) chk("done_timeout", done, 1'b1);
    start = hold;
  endtask

  task automatic back_to_idle();
    @(posedge clk);
    #1;
    chk("idle_after_done", busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rd_en"}, mem_rd_en, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 16'h0);
    chk({tag, "_we"}, we, 1'b0);
    chk({tag, "_w_addr"}, w_addr, 4'h0);
    chk({tag, "_w_data"}, w_data, 128'h0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, rd0, we0, dn0, guard;
    logic [127:0] last_vec;
    rst = 1'b1; start = 1'b0; dst_reg = '0; base_addr = '0; stride = '0;
    spur_vld = 1'b0; spur_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic load with 1-cycle latency: 9 cycles accept edge to edge after done.
    rd0 = rd_cnt; we0 = we_cnt;
    prep(4'd5, 16'h0010, 16'd1, 1, 1, 1, 1);
    go(1'b0, 1'b0, n);
    chk("basic_cycles", n + 1, 9);
    chk("basic_w_data_const", w_data, 128'h44444444_33333333_22222222_11111111);
    back_to_idle();
    chk("basic_rd_count", rd_cnt - rd0, 4);
    chk("basic_we_count", we_cnt - we0, 1);

    // Address wrap at 2^16.
    prep(4'd3, 16'hFFFE, 16'd3, 1, 1, 1, 1);
    go(1'b0, 1'b0, n);
    chk("wrap_cycles", n + 1, 9);
    back_to_idle();

    // Variable latency, then stride 0.
    rd0 = rd_cnt; we0 = we_cnt;
    prep(4'd12, 16'h0100, 16'd7, 1, 5, 2, 7);
    go(1'b0, 1'b0, n);
    back_to_idle();
    chk("varlat_rd_count", rd_cnt - rd0, 4);
    chk("varlat_we_count", we_cnt - we0, 1);
    prep(4'd7, 16'h0030, 16'd0, 2, 1, 1, 3);
    go(1'b0, 1'b0, n);
    back_to_idle();
    last_vec = {4{word_of(16'h0030)}};
    chk("stride0_w_data", w_data, last_vec);

    // Spurious valid in IDLE, then a load with start pulses and a spurious valid in REQ.
    spur_vld = 1'b1; spur_dat = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1;
    spur_vld = 1'b0;
    chk("idle_spur_busy", busy, 1'b0);
    chk("idle_spur_w_data", w_data, last_vec);
    rd0 = rd_cnt; we0 = we_cnt; dn0 = done_cnt;
    prep(4'd9, 16'h0200, 16'd2, 3, 3, 3, 3);
    go(1'b1, 1'b0, n);
    back_to_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("intf_rd_count", rd_cnt - rd0, 4);
    chk("intf_we_count", we_cnt - we0, 1);
    chk("intf_done_count", done_cnt - dn0, 1);
    chk("intf_idle_busy", busy, 1'b0);

    // Reset in WAIT after two lanes, with a late return arriving in IDLE.
    rd0 = rd_cnt; we0 = we_cnt;
    prep(4'd6, 16'h0400, 16'd1, 1, 1, 8, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (rd_cnt - rd0 < 3 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (rd_cnt - rd0 < 3) chk("abort_rd_timeout", rd_cnt - rd0, 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all_zero("abort");
    exp_addr_q.delete();
    exp_wr_q.delete();
    lat_q.delete();
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_we", we_cnt - we0, 0);
    chk("abort_late_w_data", w_data, 128'h0);
    chk("abort_late_busy", busy, 1'b0);
    prep(4'd11, 16'h0500, 16'd5, 1, 2, 1, 1);
    go(1'b0, 1'b0, n);
    back_to_idle();

    // Back-to-back with start held across done.
    we0 = we_cnt;
    prep(4'd2, 16'h0040, 16'd1, 1, 1, 1, 1);
    go(1'b0, 1'b1, n);
    prep(4'd10, 16'h0080, 16'd4, 1, 1, 1, 1);
    @(posedge clk);
    #1;
    chk("b2b_idle_gap", busy, 1'b0);
    go(1'b0, 1'b0, n);
    chk("b2b_cycles", n + 1, 9);
    back_to_idle();
    chk("b2b_we_count", we_cnt - we0, 2);

    repeat (2) @(posedge clk);
    #1;
    chk("left_writes", exp_wr_q.size(), 0);
    chk("left_addrs", exp_addr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
